// File: rtl/binary_adder_pkg.sv
// Shared constants and result type for the binary_adder slice.
// The optional signed-overflow output of binary_adder is enabled by
// defining BINARY_ADDER_OVF_EN.
package binary_adder_pkg;

    // Default operand/sum width of binary_adder.
    localparam int unsigned BA_WIDTH = 4;

    // Widest operand width binary_adder supports.
    localparam int unsigned BA_MAX_WIDTH = 32;

    // One addition result. The sum field holds the widest supported width,
    // so narrower sums sit in the low bits with the upper bits at zero.
    typedef struct packed {
        logic [BA_MAX_WIDTH-1:0] sum;
        logic                    carry;
        logic                    ovf;
    } ba_result_t;

endpackage : binary_adder_pkg

// File: rtl/binary_adder_full_adder.sv
// Single-bit full adder: one stage of the binary_adder ripple chain.
// Purely combinational. binary_adder instantiates it whether or not
// BINARY_ADDER_OVF_EN is defined.
module full_adder (
    output logic s,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);

    // Sum bit and carry to the next stage.
    always_comb begin
        s     = a ^ b ^ c_in;
        c_out = (a & b) | (c_in & (a ^ b));
    end

endmodule : full_adder

// File: rtl/binary_adder.sv
// Registered ripple-carry adder: {c_out, s} = a + b + c_in, one cycle latency.
// Operands are sampled only on cycles where in_valid is high. The results
// hold their value while in_valid is low.
// Defining BINARY_ADDER_OVF_EN adds the registered signed-overflow output ovf.
module binary_adder
    import binary_adder_pkg::*;
#(
    parameter int unsigned WIDTH = BA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
`ifdef BINARY_ADDER_OVF_EN
    output logic             ovf,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic             out_valid
);

    // carry[i] enters stage i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .s     (sum[i]),
            .c_out (carry[i+1]),
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i])
        );
    end

    // Capture sum and carry only on valid cycles; otherwise hold the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s     <= '0;
            c_out <= 1'b0;
        end else if (in_valid) begin
            s     <= sum;
            c_out <= carry[WIDTH];
        end
    end

    // out_valid follows in_valid one cycle later. Reset drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

`ifdef BINARY_ADDER_OVF_EN
    // Signed overflow: the carry into the MSB differs from the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= carry[WIDTH-1] ^ carry[WIDTH];
        end
    end
`endif

endmodule : binary_adder

// File: tb/tb_binary_adder.sv
// Scoreboard testbench for binary_adder: the driver queues expected results
// and the monitor pops and compares them whenever out_valid is high.
// Build with BINARY_ADDER_OVF_EN defined to also check ovf.
module tb_binary_adder;
    import binary_adder_pkg::*;

    localparam int unsigned W = BA_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] s;
    logic         c_out;
    logic         out_valid;
`ifdef BINARY_ADDER_OVF_EN
    logic         ovf;
`endif

    ba_result_t exp_q[$];
    ba_result_t last_res = '0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    binary_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .c_out     (c_out),
`ifdef BINARY_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .in_valid  (in_valid),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, signed overflow by range test.
    function automatic ba_result_t model(int unsigned av, int unsigned bv, int unsigned ci);
        ba_result_t r;
        longint full;
        longint sa;
        longint sb;
        longint ss;
        full = longint'(av) + longint'(bv) + longint'(ci);
        sa = (av >= (1 << (W - 1))) ? longint'(av) - (longint'(1) << W) : longint'(av);
        sb = (bv >= (1 << (W - 1))) ? longint'(bv) - (longint'(1) << W) : longint'(bv);
        ss = sa + sb + longint'(ci);
        r = '0;
        r.sum = 32'(full % (longint'(1) << W));
        r.carry = (full >= (longint'(1) << W));
        r.ovf = (ss > ((longint'(1) << (W - 1)) - 1)) || (ss < -(longint'(1) << (W - 1)));
        return r;
    endfunction

    task automatic check(string name, longint act, longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic issue(int unsigned av, int unsigned bv, int unsigned ci);
        @(posedge clk);
        #1;
        a = W'(av);
        b = W'(bv);
        c_in = ci[0];
        in_valid = 1'b1;
        exp_q.push_back(model(av, bv, ci));
    endtask

    task automatic idle(int unsigned n, int unsigned av, int unsigned bv);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = W'(av);
            b = W'(bv);
            c_in = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: compare fresh results against the queue; otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                check("pending_result", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    ba_result_t e;
                    e = exp_q.pop_front();
                    check("carry_sum", longint'({c_out, s}), longint'({e.carry, e.sum[W-1:0]}));
`ifdef BINARY_ADDER_OVF_EN
                    check("ovf", longint'(ovf), longint'(e.ovf));
`endif
                    last_res = e;
                end
            end else begin
                check("hold_carry_sum", longint'({c_out, s}),
                      longint'({last_res.carry, last_res.sum[W-1:0]}));
`ifdef BINARY_ADDER_OVF_EN
                check("hold_ovf", longint'(ovf), longint'(last_res.ovf));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned combos[];
        int unsigned ncomb;

        // Reset state.
        #2;
        check("reset_sum", longint'(s), 0);
        check("reset_carry", longint'(c_out), 0);
        check("reset_out_valid", longint'(out_valid), 0);
`ifdef BINARY_ADDER_OVF_EN
        check("reset_ovf", longint'(ovf), 0);
`endif

        // Operands presented before release are taken at the first edge after it.
        #10;
        a = W'(4);
        b = W'(7);
        c_in = 1'b0;
        in_valid = 1'b1;
        exp_q.push_back(model(4, 7, 0));
        rst_n = 1'b1;

        // Hold with different operands on the bus.
        idle(3, 3, 3);

        // Zero operands back to back.
        issue(0, 7, 0);
        issue(7, 0, 0);
        idle(1, 0, 0);

        // Carry out, full-scale wrap, signed overflow.
        issue(15, 1, 0);
        issue(15, 15, 1);
        issue(7, 1, 0);
        issue(8, 8, 0);
        idle(2, 0, 0);

        // Reset between edges while an operation is being presented.
        issue(5, 5, 0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        last_res = '0;
        #1;
        check("midreset_sum", longint'(s), 0);
        check("midreset_carry", longint'(c_out), 0);
        check("midreset_out_valid", longint'(out_valid), 0);
`ifdef BINARY_ADDER_OVF_EN
        check("midreset_ovf", longint'(ovf), 0);
`endif
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(3, 9, 9);

        // Every (a, b, c_in) combination in shuffled order with random gaps.
        ncomb = 1 << (2 * W + 1);
        combos = new[ncomb];
        for (int unsigned i = 0; i < ncomb; i++) combos[i] = i;
        for (int unsigned i = ncomb - 1; i > 0; i--) begin
            int unsigned j;
            int unsigned t;
            j = $urandom_range(0, i);
            t = combos[i];
            combos[i] = combos[j];
            combos[j] = t;
        end
        for (int unsigned i = 0; i < ncomb; i++) begin
            int unsigned v;
            v = combos[i];
            issue(v % (1 << W), (v >> W) % (1 << W), v >> (2 * W));
            if ($urandom_range(0, 7) == 0) idle(1, $urandom, $urandom);
        end

        idle(3, 0, 0);
        check("queue_drained", longint'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_binary_adder
